// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues one instruction-memory request at a
// time, registers the returned word for decode and computes the next PC on consume.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic        uncond_jump,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] instr_reg;
    logic [31:0] instret_reg;
    logic        consume;
    logic        target_misaligned;

    assign pc_plus4 = pc_reg + 32'd4;
    assign consume  = (state_reg == VALID) && !stall;
    assign target_misaligned = (pc_next[1:0] != 2'b00);

    // Branch target; pc_src==11 deliberately falls through to sequential fetch.
    always_comb begin
        pc_next = pc_plus4;
        case (pc_src)
            2'b01: begin
                if (uncond_jump || branch_taken) begin
                    pc_next = pc_reg + imm;
                end
            end
            2'b10: pc_next = (rs1_val + imm) & 32'hFFFF_FFFE;
            default: pc_next = pc_plus4;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            REQ:   state_next = WAIT;
            WAIT:  if (imem_rvalid) state_next = VALID;
            VALID: begin
                if (!stall) begin
                    state_next = target_misaligned ? ERR : REQ;
                end
            end
            ERR:   state_next = ERR;
            default: state_next = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    // A misaligned target leaves pc at the offending instruction but still retires it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_reg      <= RESET_PC;
            instr_reg   <= 32'd0;
            instret_reg <= 32'd0;
        end else begin
            if (state_reg == WAIT && imem_rvalid) begin
                instr_reg <= imem_rdata;
            end
            if (consume) begin
                instret_reg <= instret_reg + 32'd1;
                if (!target_misaligned) begin
                    pc_reg <= pc_next;
                end
            end
        end
    end

    // Request is gated by reset since the state register already reads REQ during reset.
    assign imem_req    = (state_reg == REQ) && n_rst;
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == VALID);
    assign instr       = instr_reg;
    assign opcode      = instr_reg[6:0];
    assign pc          = pc_reg;
    assign misaligned  = (state_reg == ERR);
    assign instret     = instret_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table walks the PC through sequential,
// branch, jump and JALR targets, plus hand sequences for stall, reset and PC wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic        uncond_jump;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] instret;

    logic        n_rst2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [6:0]  opcode2;
    logic [31:0] pc2;
    logic [31:0] pc_plus4_2;
    logic        misaligned2;
    logic [31:0] instret2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .n_rst(n_rst), .stall(stall), .pc_src(pc_src),
        .uncond_jump(uncond_jump), .branch_taken(branch_taken), .imm(imm),
        .rs1_val(rs1_val), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc(pc),
        .pc_plus4(pc_plus4), .misaligned(misaligned), .instret(instret)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .n_rst(n_rst2), .stall(stall), .pc_src(pc_src),
        .uncond_jump(uncond_jump), .branch_taken(branch_taken), .imm(imm),
        .rs1_val(rs1_val), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .instr_valid(instr_valid2), .instr(instr2), .opcode(opcode2), .pc(pc2),
        .pc_plus4(pc_plus4_2), .misaligned(misaligned2), .instret(instret2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  src;
        logic        uj;
        logic        bt;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] next;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        step();
        step();
        n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00, 2'b00, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0013, 0, 32'h04, 1'b0};
        vecs[1]  = '{32'h04, 2'b00, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0010_0093, 0, 32'h08, 1'b0};
        vecs[2]  = '{32'h08, 2'b01, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'h0000_0463, 1, 32'h10, 1'b0};
        vecs[3]  = '{32'h10, 2'b01, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'hFE00_0CE3, 0, 32'h08, 1'b0};
        vecs[4]  = '{32'h08, 2'b01, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h1000_0063, 2, 32'h0C, 1'b0};
        vecs[5]  = '{32'h0C, 2'b01, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0040_006F, 0, 32'h10, 1'b0};
        vecs[6]  = '{32'h10, 2'b01, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'hFE00_1CE3, 0, 32'h14, 1'b0};
        vecs[7]  = '{32'h14, 2'b01, 1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'hFF5F_F0EF, 1, 32'h08, 1'b0};
        vecs[8]  = '{32'h08, 2'b11, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 32'h0000_0033, 0, 32'h0C, 1'b0};
        vecs[9]  = '{32'h0C, 2'b10, 1'b0, 1'b0, 32'h0000_0003, 32'h101, 32'h0030_80E7, 0, 32'h104, 1'b0};
        vecs[10] = '{32'h104, 2'b10, 1'b0, 1'b0, 32'h0000_0003, 32'h103, 32'h0030_8067, 0, 32'h104, 1'b1};

        n_rst = 1'b0; n_rst2 = 1'b0;
        stall = 1'b0; pc_src = 2'b00; uncond_jump = 1'b0; branch_taken = 1'b0;
        imm = 32'h0; rs1_val = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        imem_rvalid2 = 1'b0; imem_rdata2 = 32'h0;
        step();
        step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_instret", instret, 32'd0);
        n_rst = 1'b1;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // Table walk: at loop entry the DUT sits in REQ for vecs[i].pc.
        for (int i = 0; i < 11; i++) begin
            check("req_pulse", {31'd0, imem_req}, 32'd1);
            check("req_addr", imem_addr, vecs[i].pc);
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_0000;
            step();
            check("wait_req", {31'd0, imem_req}, 32'd0);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            imem_rvalid = 1'b0;
            for (int k = 0; k < vecs[i].lat; k++) begin
                step();
                check("lat_valid", {31'd0, instr_valid}, 32'd0);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = vecs[i].rdata;
            step();
            imem_rvalid = 1'b0;
            check("instr_valid", {31'd0, instr_valid}, 32'd1);
            check("instr", instr, vecs[i].rdata);
            check("opcode", {25'd0, opcode}, vecs[i].rdata & 32'h7F);
            check("pc", pc, vecs[i].pc);
            check("pc_plus4", pc_plus4, vecs[i].pc + 32'd4);
            check("instret", instret, i);
            check("valid_req", {31'd0, imem_req}, 32'd0);
            pc_src = vecs[i].src; uncond_jump = vecs[i].uj; branch_taken = vecs[i].bt;
            imm = vecs[i].imm; rs1_val = vecs[i].rs1;
            step();
            $display("[TB] vec %0d pc=%h src=%b next=%h instret=%0d misaligned=%0d",
                     i, vecs[i].pc, vecs[i].src, imem_addr, instret, misaligned);
            check("instret_after", instret, i + 1);
            if (!vecs[i].err) begin
                check("next_req", {31'd0, imem_req}, 32'd1);
                check("next_addr", imem_addr, vecs[i].next);
            end else begin
                check("err_misaligned", {31'd0, misaligned}, 32'd1);
                check("err_valid", {31'd0, instr_valid}, 32'd0);
                check("err_pc", pc, vecs[i].next);
                for (int k = 0; k < 5; k++) begin
                    check("err_req", {31'd0, imem_req}, 32'd0);
                    step();
                end
                check("err_sticky", {31'd0, misaligned}, 32'd1);
            end
        end
        pc_src = 2'b00; uncond_jump = 1'b0; branch_taken = 1'b0; imm = 32'h0; rs1_val = 32'h0;

        // Stall holds VALID; the pending jump target lands only when stall drops.
        do_reset();
        #1;
        check("stall_req", {31'd0, imem_req}, 32'd1);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        stall = 1'b1; pc_src = 2'b01; uncond_jump = 1'b1; imm = 32'h40;
        step();
        imem_rvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, 32'hDEAD_BEEF);
            check("stall_pc", pc, 32'h0);
            check("stall_noreq", {31'd0, imem_req}, 32'd0);
            check("stall_instret", instret, 32'd0);
            step();
        end
        $display("[TB] stall held 5 cycles instr=%h pc=%h", instr, pc);
        stall = 1'b0;
        step();
        check("unstall_req", {31'd0, imem_req}, 32'd1);
        check("unstall_addr", imem_addr, 32'h40);
        check("unstall_instret", instret, 32'd1);
        pc_src = 2'b00; uncond_jump = 1'b0; imm = 32'h0;

        // Asynchronous reset in WAIT at a non-reset PC.
        step();
        check("pre_rst_pc", pc, 32'h40);
        n_rst = 1'b0;
        #1;
        $display("[TB] reset in WAIT pc=%h instr_valid=%0d", pc, instr_valid);
        check("arst_pc", pc, 32'h0);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_instret", instret, 32'd0);
        step();
        n_rst = 1'b1;
        #1;
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);

        // PC wrap from a top-of-memory reset vector.
        n_rst2 = 1'b1;
        #1;
        check("wrap_req", {31'd0, imem_req2}, 32'd1);
        check("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4_2, 32'h0);
        step();
        imem_rvalid2 = 1'b1; imem_rdata2 = 32'h0000_0013;
        step();
        imem_rvalid2 = 1'b0;
        check("wrap_valid", {31'd0, instr_valid2}, 32'd1);
        step();
        $display("[TB] wrap pc=FFFFFFFC next=%h", imem_addr2);
        check("wrap_next_req", {31'd0, imem_req2}, 32'd1);
        check("wrap_next_addr", imem_addr2, 32'h0);
        check("wrap_misaligned", {31'd0, misaligned2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
